spike_aer_encoder: RTL and testbench

//  Downstream of the spike encoder. Converts the per-time-step spike vector (one bit per input)

---
 rtl/spike_aer_encoder.sv | 139 +++++++++++++
 tb/tb_spike_aer_encoder.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spike_aer_encoder.sv
// Serialises a captured spike vector into an address-event stream: one event per set bit,
// ascending, followed by an end-of-step marker carrying the number of events emitted.
module spike_aer_encoder #(
    parameter int INPUT_SIZE = 3072,
    parameter int CHUNK      = 32,
    parameter int ADDR_W     = $clog2(INPUT_SIZE),
    parameter int CNT_W      = $clog2(INPUT_SIZE + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [INPUT_SIZE-1:0] spike_in,
    input  logic                  time_step_pulse,
    output logic                  aer_valid,
    input  logic                  aer_ready,
    output logic [ADDR_W-1:0]     aer_addr,
    output logic                  aer_eos,
    output logic [CNT_W-1:0]      aer_count,
    output logic                  busy,
    output logic                  overrun
);

    localparam int NCHUNK = INPUT_SIZE / CHUNK;
    localparam int CIDX_W = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam int LOW_W  = (CHUNK > 1) ? $clog2(CHUNK) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SCAN = 2'd1;
    localparam logic [1:0] S_EOS  = 2'd2;

    generate
        if (INPUT_SIZE % CHUNK != 0) begin : g_size_check
            $error("spike_aer_encoder: INPUT_SIZE must be a multiple of CHUNK");
        end
    endgenerate

    logic [1:0]            r_state;
    logic [INPUT_SIZE-1:0] r_snapshot;
    logic [CIDX_W-1:0]     r_chunk;
    logic [CNT_W-1:0]      r_count;
    logic                  r_valid;
    logic [ADDR_W-1:0]     r_addr;
    logic                  r_eos;
    logic [CNT_W-1:0]      r_aer_count;
    logic                  r_busy;
    logic                  r_overrun;

    logic [CHUNK-1:0]      w_window;
    logic [CHUNK-1:0]      w_rest;
    logic [LOW_W-1:0]      w_low;
    logic                  w_slot_free;
    logic                  w_last_chunk;
    logic [ADDR_W-1:0]     w_event_addr;

    assign w_window     = r_snapshot[r_chunk*CHUNK +: CHUNK];
    // Window with its lowest set bit removed; zero means this event empties the chunk.
    assign w_rest       = w_window & (w_window - CHUNK'(1));
    assign w_slot_free  = !r_valid || aer_ready;
    assign w_last_chunk = (r_chunk == CIDX_W'(NCHUNK - 1));
    assign w_event_addr = ADDR_W'(r_chunk) * ADDR_W'(CHUNK) + ADDR_W'(w_low);

    always_comb begin
        w_low = '0;
        for (int i = CHUNK - 1; i >= 0; i--) begin
            if (w_window[i]) w_low = LOW_W'(i);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_snapshot  <= '0;
            r_chunk     <= '0;
            r_count     <= '0;
            r_valid     <= 1'b0;
            r_addr      <= '0;
            r_eos       <= 1'b0;
            r_aer_count <= '0;
            r_busy      <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            if (time_step_pulse && r_busy) r_overrun <= 1'b1;

            case (r_state)
                S_IDLE: begin
                    // busy already set in IDLE marks the one-cycle capture slot before scanning.
                    if (r_busy) begin
                        r_state <= S_SCAN;
                    end else if (time_step_pulse) begin
                        r_snapshot <= spike_in;
                        r_chunk    <= '0;
                        r_count    <= '0;
                        r_busy     <= 1'b1;
                    end
                end
                S_SCAN: begin
                    if (w_window == '0) begin
                        if (w_last_chunk) r_state <= S_EOS;
                        else              r_chunk <= r_chunk + CIDX_W'(1);
                        if (w_slot_free) r_valid <= 1'b0;
                    end else if (w_slot_free) begin
                        r_valid <= 1'b1;
                        r_addr  <= w_event_addr;
                        r_count <= r_count + CNT_W'(1);
                        r_snapshot[r_chunk*CHUNK +: CHUNK] <= w_rest;
                        // Advance alongside the final event of a chunk so full chunks run gap-free.
                        if (w_rest == '0) begin
                            if (w_last_chunk) r_state <= S_EOS;
                            else              r_chunk <= r_chunk + CIDX_W'(1);
                        end
                    end
                end
                S_EOS: begin
                    if (!r_eos) begin
                        if (w_slot_free) begin
                            r_valid     <= 1'b1;
                            r_eos       <= 1'b1;
                            r_addr      <= '0;
                            r_aer_count <= r_count;
                        end
                    end else if (aer_ready) begin
                        r_valid <= 1'b0;
                        r_eos   <= 1'b0;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign aer_valid = r_valid;
    assign aer_addr  = r_addr;
    assign aer_eos   = r_eos;
    assign aer_count = r_aer_count;
    assign busy      = r_busy;
    assign overrun   = r_overrun;

endmodule

// File: tb/tb_spike_aer_encoder.sv
// Bench for spike_aer_encoder: a queue-based reference of the expected event stream per step,
// a table of directed vectors, hand-written stall/overrun/reset sequences and random steps.
module tb_spike_aer_encoder;
    localparam int N  = 3072;
    localparam int C  = 32;
    localparam int AW = 12;
    localparam int CW = 12;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [N-1:0]  spike_in = '0;
    logic          time_step_pulse = 1'b0;
    logic          aer_ready = 1'b0;
    logic          aer_valid;
    logic [AW-1:0] aer_addr;
    logic          aer_eos;
    logic [CW-1:0] aer_count;
    logic          busy;
    logic          overrun;

    spike_aer_encoder #(.INPUT_SIZE(N), .CHUNK(C)) dut (
        .clk(clk), .rst_n(rst_n), .spike_in(spike_in), .time_step_pulse(time_step_pulse),
        .aer_valid(aer_valid), .aer_ready(aer_ready), .aer_addr(aer_addr), .aer_eos(aer_eos),
        .aer_count(aer_count), .busy(busy), .overrun(overrun)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: expected stream = ascending indices of set bits, then marker with popcount.
    typedef struct {bit eos; int addr; int cnt;} item_t;
    item_t exp_q[$];
    int eos_seen     = 0;
    int last_eos_cnt = -1;
    int ready_mode   = 1;  // 0 = low, 1 = high, 2 = random

    task automatic push_expect(input logic [N-1:0] v);
        int c;
        item_t it;
        c = 0;
        for (int i = 0; i < N; i++) begin
            if (v[i]) begin
                it.eos = 1'b0; it.addr = i; it.cnt = 0;
                exp_q.push_back(it);
                c++;
            end
        end
        it.eos = 1'b1; it.addr = 0; it.cnt = c;
        exp_q.push_back(it);
    endtask

    // Monitor: handshakes and hold-stability, sampled on the falling edge.
    initial begin
        bit            prev_stall;
        logic [AW-1:0] prev_addr;
        logic          prev_eos;
        logic [CW-1:0] prev_cnt;
        item_t         it;
        prev_stall = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    check("hold_valid", aer_valid, 1);
                    check("hold_addr", aer_addr, prev_addr);
                    check("hold_eos", aer_eos, prev_eos);
                    check("hold_count", aer_count, prev_cnt);
                end
                if (aer_valid && aer_ready) begin
                    if (exp_q.size() == 0) begin
                        check("item_expected", exp_q.size(), 1);
                    end else begin
                        it = exp_q.pop_front();
                        check("item_eos", aer_eos, it.eos);
                        if (it.eos) begin
                            check("eos_addr_zero", aer_addr, 0);
                            check("eos_count", aer_count, it.cnt);
                            last_eos_cnt = aer_count;
                            eos_seen++;
                        end else begin
                            check("event_addr", aer_addr, it.addr);
                        end
                    end
                end
                prev_stall = aer_valid && !aer_ready;
                prev_addr  = aer_addr;
                prev_eos   = aer_eos;
                prev_cnt   = aer_count;
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       aer_ready = 1'b0;
                1:       aer_ready = 1'b1;
                default: aer_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Applies a pulse across one active edge, then scrambles spike_in to show it is ignored.
    task automatic pulse_step(input logic [N-1:0] v);
        spike_in = v;
        time_step_pulse = 1'b1;
        @(posedge clk);
        #1;
        time_step_pulse = 1'b0;
        spike_in = {96{$urandom()}};
    endtask

    task automatic wait_eos(input int target, input int budget);
        int k;
        k = 0;
        while (eos_seen < target && k < budget) begin
            @(posedge clk);
            #1;
            k++;
        end
        check("eos_reached", eos_seen >= target, 1);
    endtask

    typedef struct {logic [N-1:0] spikes; int first_lat; int exp_cnt;} vec_t;
    vec_t tbl[5];

    initial begin
        logic [N-1:0] v;
        logic [N-1:0] case2;
        int k;
        int target;
        int bad;

        case2 = '0;
        case2[0] = 1'b1; case2[5] = 1'b1; case2[31] = 1'b1; case2[32] = 1'b1; case2[3071] = 1'b1;

        tbl[0].spikes = '0;      tbl[0].first_lat = 98; tbl[0].exp_cnt = 0;
        tbl[1].spikes = case2;   tbl[1].first_lat = 2;  tbl[1].exp_cnt = 5;
        v = '0; v[3071] = 1'b1;
        tbl[2].spikes = v;       tbl[2].first_lat = 97; tbl[2].exp_cnt = 1;
        v = '0; v[63:32] = '1;
        tbl[3].spikes = v;       tbl[3].first_lat = 3;  tbl[3].exp_cnt = 32;
        v = '0; v[100] = 1'b1; v[1000] = 1'b1; v[2047] = 1'b1;
        tbl[4].spikes = v;       tbl[4].first_lat = 5;  tbl[4].exp_cnt = 3;

        // Reset state
        #12;
        check("rst_valid", aer_valid, 0);
        check("rst_eos", aer_eos, 0);
        check("rst_addr", aer_addr, 0);
        check("rst_count", aer_count, 0);
        check("rst_busy", busy, 0);
        check("rst_overrun", overrun, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        ready_mode = 1;

        // Directed table, ready held high
        foreach (tbl[t]) begin
            target = eos_seen + 1;
            push_expect(tbl[t].spikes);
            pulse_step(tbl[t].spikes);
            check("busy_captured", busy, 1);
            k = 0;
            while (!aer_valid && k < 200) begin
                @(posedge clk);
                #1;
                k++;
            end
            check("first_valid_latency", k, tbl[t].first_lat);
            check("first_item_is_eos", aer_eos, (tbl[t].exp_cnt == 0) ? 1 : 0);
            wait_eos(target, 400);
            check("table_eos_count", last_eos_cnt, tbl[t].exp_cnt);
            check("busy_after_eos", busy, 0);
            $display("vector %0d: first valid after %0d cycles, EOS count %0d", t, k, last_eos_cnt);
        end

        // Consumer stalls 10 cycles on the first event
        ready_mode = 0;
        @(posedge clk);
        #1;
        target = eos_seen + 1;
        push_expect(case2);
        pulse_step(case2);
        k = 0;
        while (!aer_valid && k < 50) begin
            @(posedge clk);
            #1;
            k++;
        end
        for (int i = 0; i < 10; i++) begin
            check("stall_valid", aer_valid, 1);
            check("stall_addr", aer_addr, 0);
            @(posedge clk);
            #1;
        end
        ready_mode = 1;
        wait_eos(target, 400);
        check("stall_eos_count", last_eos_cnt, 5);
        $display("stall sequence: EOS count %0d", last_eos_cnt);

        // Pulse during scan is an overrun and leaves the step intact
        check("overrun_clear_before", overrun, 0);
        target = eos_seen + 1;
        push_expect(case2);
        pulse_step(case2);
        repeat (3) begin @(posedge clk); #1; end
        v = '1;
        pulse_step(v);
        check("overrun_set", overrun, 1);
        wait_eos(target, 400);
        check("overrun_eos_count", last_eos_cnt, 5);
        check("overrun_busy_dropped", busy, 0);
        v = '0; v[7] = 1'b1;
        target = eos_seen + 1;
        push_expect(v);
        pulse_step(v);
        check("next_pulse_accepted", busy, 1);
        wait_eos(target, 400);
        check("next_step_count", last_eos_cnt, 1);
        check("overrun_sticky", overrun, 1);
        $display("overrun sequence: overrun=%0d, next step count %0d", overrun, last_eos_cnt);

        // Asynchronous reset mid-scan
        exp_q.push_back('{1'b0, 0, 0});
        exp_q.push_back('{1'b0, 5, 0});
        exp_q.push_back('{1'b0, 31, 0});
        exp_q.push_back('{1'b0, 32, 0});
        pulse_step(case2);
        repeat (20) begin @(posedge clk); #1; end
        check("midscan_busy", busy, 1);
        #3;
        rst_n = 1'b0;
        #1;
        check("async_rst_valid", aer_valid, 0);
        check("async_rst_eos", aer_eos, 0);
        check("async_rst_addr", aer_addr, 0);
        check("async_rst_count", aer_count, 0);
        check("async_rst_busy", busy, 0);
        check("async_rst_overrun", overrun, 0);
        check("pre_reset_items_drained", exp_q.size(), 0);
        exp_q.delete();
        #12;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        bad = 0;
        for (int i = 0; i < 150; i++) begin
            if (aer_valid) bad++;
            @(posedge clk);
            #1;
        end
        check("no_eos_after_reset", bad, 0);
        v = '0; v[9] = 1'b1;
        target = eos_seen + 1;
        push_expect(v);
        pulse_step(v);
        wait_eos(target, 400);
        check("post_reset_count", last_eos_cnt, 1);
        $display("reset sequence: post-reset step count %0d", last_eos_cnt);

        // All ones: 3072 gap-free events
        target = eos_seen + 1;
        v = '1;
        push_expect(v);
        pulse_step(v);
        k = 0;
        while (!aer_valid && k < 50) begin
            @(posedge clk);
            #1;
            k++;
        end
        check("all_ones_latency", k, 2);
        bad = 0;
        for (int i = 0; i < N; i++) begin
            if (!(aer_valid && !aer_eos && aer_addr == AW'(i))) bad++;
            @(posedge clk);
            #1;
        end
        check("all_ones_gaps", bad, 0);
        check("all_ones_eos_next", aer_eos, 1);
        wait_eos(target, 100);
        check("all_ones_count", last_eos_cnt, 3072);
        $display("all-ones step: EOS count %0d", last_eos_cnt);

        // Random vectors with random back-pressure
        ready_mode = 2;
        for (int j = 0; j < 6; j++) begin
            v = '0;
            if (j == 5) begin
                v = {96{$urandom()}};
            end else begin
                repeat ($urandom_range(0, 40)) v[$urandom_range(0, N - 1)] = 1'b1;
            end
            target = eos_seen + 1;
            push_expect(v);
            pulse_step(v);
            wait_eos(target, 12000);
            $display("random step %0d: EOS count %0d", j, last_eos_cnt);
        end
        ready_mode = 1;
        repeat (3) begin @(posedge clk); #1; end
        check("queue_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
